// File: rtl/axi_lite_mem_bridge_pkg.sv
// Shared types and response codes for the AXI-lite to Ibex memory-port bridge.
package axi_lite_mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      RD_RESP,
      WR_REQ,
      WR_WAIT,
      WR_RESP
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_chan_buf.sv
// Single-entry holding register for one AXI-lite request channel.
// ready_o is registered and tracks ~full, so it is low in reset and high one cycle later.
module axi_lite_chan_buf #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] data_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic         clr_i,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         full_q;
   logic         full_d;
   logic         ready_q;
   logic         hs;
   logic [W-1:0] data_q;

   assign hs = valid_i & ready_q;

   // The owner clears only a full entry, and a full entry is never ready, so clear and capture never collide.
   always_comb begin
      full_d = (full_q & ~clr_i) | hs;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         full_q  <= full_d;
         ready_q <= ~full_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (hs) begin
         data_q <= data_i;
      end
   end

   assign ready_o = ready_q;
   assign full_o  = full_q;
   assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_mem_bridge.sv
// AXI-lite subordinate to Ibex-style req/gnt/rvalid memory port, one transaction at a time.
module axi_lite_mem_bridge
   import axi_lite_mem_bridge_pkg::*;
#(
   parameter int AXI_AW = 16,
   parameter int AXI_DW = 32,
   parameter int MEM_AW = 32,
   parameter int MEM_DW = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [AXI_AW-1:0]   aw_addr_i,
   input  logic                aw_valid_i,
   output logic                aw_ready_o,
   input  logic [AXI_DW-1:0]   w_data_i,
   input  logic [AXI_DW/8-1:0] w_strb_i,
   input  logic                w_valid_i,
   output logic                w_ready_o,
   output logic [1:0]          b_resp_o,
   output logic                b_valid_o,
   input  logic                b_ready_i,
   input  logic [AXI_AW-1:0]   ar_addr_i,
   input  logic                ar_valid_i,
   output logic                ar_ready_o,
   output logic [AXI_DW-1:0]   r_data_o,
   output logic [1:0]          r_resp_o,
   output logic                r_valid_o,
   input  logic                r_ready_i,
   output logic                req_o,
   input  logic                gnt_i,
   input  logic                rvalid_i,
   output logic                we_o,
   output logic [3:0]          be_o,
   output logic [MEM_AW-1:0]   addr_o,
   output logic [MEM_DW-1:0]   wdata_o,
   input  logic [MEM_DW-1:0]   rdata_i,
   input  logic                err_i
);

   state_e                state_q, state_d;
   logic                  last_wr_q;
   logic                  aw_full, w_full, ar_full;
   logic                  clr_wr, clr_rd;
   logic [AXI_AW-1:0]     aw_addr_q, ar_addr_q;
   logic [AXI_DW-1:0]     w_data_q;
   logic [AXI_DW/8-1:0]   w_strb_q;
   logic [1:0]            b_resp_q, r_resp_q;
   logic [AXI_DW-1:0]     r_data_q;
   logic                  wr_elig, rd_elig;

   axi_lite_chan_buf #(.W(AXI_AW)) u_aw_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (aw_addr_i),
      .valid_i (aw_valid_i),
      .ready_o (aw_ready_o),
      .clr_i   (clr_wr),
      .full_o  (aw_full),
      .data_o  (aw_addr_q)
   );

   axi_lite_chan_buf #(.W(AXI_DW + AXI_DW/8)) u_w_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  ({w_strb_i, w_data_i}),
      .valid_i (w_valid_i),
      .ready_o (w_ready_o),
      .clr_i   (clr_wr),
      .full_o  (w_full),
      .data_o  ({w_strb_q, w_data_q})
   );

   axi_lite_chan_buf #(.W(AXI_AW)) u_ar_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (ar_addr_i),
      .valid_i (ar_valid_i),
      .ready_o (ar_ready_o),
      .clr_i   (clr_rd),
      .full_o  (ar_full),
      .data_o  (ar_addr_q)
   );

   assign wr_elig = aw_full & w_full;
   assign rd_elig = ar_full;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == WR_REQ) last_wr_q <= 1'b1;
         if (state_q == IDLE && state_d == RD_REQ) last_wr_q <= 1'b0;
      end
   end

   // On a tie the direction not served last goes first, so neither side can starve the other.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (wr_elig && (!rd_elig || !last_wr_q)) state_d = WR_REQ;
            else if (rd_elig)                         state_d = RD_REQ;
         end
         WR_REQ:  if (gnt_i)     state_d = WR_WAIT;
         WR_WAIT: if (rvalid_i)  state_d = WR_RESP;
         WR_RESP: if (b_ready_i) state_d = IDLE;
         RD_REQ:  if (gnt_i)     state_d = RD_WAIT;
         RD_WAIT: if (rvalid_i)  state_d = RD_RESP;
         RD_RESP: if (r_ready_i) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      req_o     = 1'b0;
      we_o      = 1'b0;
      be_o      = 4'h0;
      addr_o    = '0;
      wdata_o   = '0;
      b_valid_o = 1'b0;
      r_valid_o = 1'b0;
      clr_wr    = 1'b0;
      clr_rd    = 1'b0;
      unique case (state_q)
         WR_REQ: begin
            req_o   = 1'b1;
            we_o    = 1'b1;
            be_o    = 4'(w_strb_q);
            addr_o  = MEM_AW'(aw_addr_q);
            wdata_o = MEM_DW'(w_data_q);
            clr_wr  = gnt_i;
         end
         RD_REQ: begin
            req_o  = 1'b1;
            be_o   = 4'hF;
            addr_o = MEM_AW'(ar_addr_q);
            clr_rd = gnt_i;
         end
         WR_RESP: b_valid_o = 1'b1;
         RD_RESP: r_valid_o = 1'b1;
         default: ;
      endcase
   end

   // rvalid_i outside the WAIT states is not ours and is dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         b_resp_q <= AXI_RESP_OKAY;
         r_resp_q <= AXI_RESP_OKAY;
         r_data_q <= '0;
      end else begin
         if (state_q == WR_WAIT && rvalid_i) begin
            b_resp_q <= err_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
         if (state_q == RD_WAIT && rvalid_i) begin
            r_data_q <= AXI_DW'(rdata_i);
            r_resp_q <= err_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
         end
      end
   end

   assign b_resp_o = b_resp_q;
   assign r_resp_o = r_resp_q;
   assign r_data_o = r_data_q;

endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Bench for axi_lite_mem_bridge: directed scenarios plus random traffic against a word-array reference memory.
module tb_axi_lite_mem_bridge;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [15:0] aw_addr_i, ar_addr_i;
   logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o;
   logic [31:0] w_data_i, r_data_o, rdata_i, wdata_o;
   logic [3:0]  w_strb_i, be_o;
   logic [1:0]  b_resp_o, r_resp_o;
   logic        b_valid_o, b_ready_i, ar_valid_i, ar_ready_o, r_valid_o, r_ready_i;
   logic        req_o, gnt_i, rvalid_i, we_o, err_i;
   logic [31:0] addr_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] dev_mem [int];
   logic [31:0] ref_mem [int];
   int          gnt_stall = 0;
   int          rv_delay  = 0;
   bit          mem_err   = 1'b0;
   int          served_we [$];

   always #5 clk_i = ~clk_i;

   axi_lite_mem_bridge dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
      .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .req_o(req_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .we_o(we_o), .be_o(be_o),
      .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i), .err_i(err_i)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      int k = int'(a >> 2);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w = ref_read(a);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[int'(a >> 2)] = w;
   endfunction

   // Memory device: grants after gnt_stall waiting cycles, answers rvalid_delay cycles after the grant cycle.
   initial begin
      logic        pend = 1'b0, waiting = 1'b0, pend_err = 1'b0;
      int          rv_cnt = 0, stall_left = 0, k;
      logic [31:0] pend_rdata = 0, h_addr = 0, h_wdata = 0, w;
      logic [3:0]  h_be = 0;
      logic        h_we = 0;
      gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0; err_i = 1'b0;
      forever begin
         @(negedge clk_i);
         rvalid_i = 1'b0; err_i = 1'b0; gnt_i = 1'b0;
         if (!rst_ni) begin
            pend = 1'b0; waiting = 1'b0;
         end else if (pend) begin
            if (rv_cnt == 0) begin
               rvalid_i = 1'b1; rdata_i = pend_rdata; err_i = pend_err; pend = 1'b0;
            end else rv_cnt--;
         end else if (req_o) begin
            if (waiting) begin
               check("req_hold_addr", addr_o, h_addr);
               check("req_hold_we", we_o, h_we);
               check("req_hold_be", be_o, h_be);
               check("req_hold_wdata", wdata_o, h_wdata);
            end else begin
               waiting = 1'b1; stall_left = gnt_stall;
               h_addr = addr_o; h_we = we_o; h_be = be_o; h_wdata = wdata_o;
            end
            if (stall_left == 0) begin
               gnt_i = 1'b1; waiting = 1'b0;
               served_we.push_back(int'(we_o));
               k = int'(addr_o >> 2);
               w = dev_mem.exists(k) ? dev_mem[k] : 32'h0;
               if (we_o && !mem_err) begin
                  for (int b = 0; b < 4; b++) if (be_o[b]) w[8*b +: 8] = wdata_o[8*b +: 8];
                  dev_mem[k] = w;
               end
               pend = 1'b1; rv_cnt = rv_delay; pend_err = mem_err;
               pend_rdata = we_o ? 32'h0 : w;
            end else stall_left--;
         end
      end
   end

   task automatic do_aw(input logic [15:0] a);
      bit ok = 1'b0;
      aw_addr_i = a; aw_valid_i = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (aw_ready_o) ok = 1'b1;
         tick(1);
      end
      aw_valid_i = 1'b0;
      check("aw_accept", ok, 1);
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] s);
      bit ok = 1'b0;
      w_data_i = d; w_strb_i = s; w_valid_i = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (w_ready_o) ok = 1'b1;
         tick(1);
      end
      w_valid_i = 1'b0;
      check("w_accept", ok, 1);
   endtask

   task automatic do_ar(input logic [15:0] a);
      bit ok = 1'b0;
      ar_addr_i = a; ar_valid_i = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (ar_ready_o) ok = 1'b1;
         tick(1);
      end
      ar_valid_i = 1'b0;
      check("ar_accept", ok, 1);
   endtask

   task automatic get_b(output logic [1:0] resp, input int hold);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (b_valid_o) seen = 1'b1;
         else tick(1);
      end
      check("b_seen", seen, 1);
      resp = b_resp_o;
      for (int i = 0; i < hold; i++) begin
         tick(1);
         check("b_hold_valid", b_valid_o, 1);
         check("b_hold_resp", b_resp_o, resp);
      end
      b_ready_i = 1'b1;
      tick(1);
      b_ready_i = 1'b0;
      check("b_drop", b_valid_o, 0);
   endtask

   task automatic get_r(output logic [31:0] data, output logic [1:0] resp, input int hold);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (r_valid_o) seen = 1'b1;
         else tick(1);
      end
      check("r_seen", seen, 1);
      data = r_data_o; resp = r_resp_o;
      for (int i = 0; i < hold; i++) begin
         tick(1);
         check("r_hold_valid", r_valid_o, 1);
         check("r_hold_data", r_data_o, data);
         check("r_hold_resp", r_resp_o, resp);
      end
      r_ready_i = 1'b1;
      tick(1);
      r_ready_i = 1'b0;
      check("r_drop", r_valid_o, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] data, d1, d3, a;
      logic [3:0]  s;
      logic [2:0]  order;
      bit          e;
      rst_ni = 1'b0;
      aw_addr_i = 0; aw_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_valid_i = 0;
      ar_addr_i = 0; ar_valid_i = 0; b_ready_i = 0; r_ready_i = 0;
      tick(3);
      check("rst_aw_ready", aw_ready_o, 0);
      check("rst_w_ready", w_ready_o, 0);
      check("rst_ar_ready", ar_ready_o, 0);
      check("rst_req", req_o, 0);
      check("rst_b_valid", b_valid_o, 0);
      check("rst_r_valid", r_valid_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_r_data", r_data_o, 0);
      rst_ni = 1'b1;
      tick(1);
      check("post_rst_aw_ready", aw_ready_o, 1);
      check("post_rst_w_ready", w_ready_o, 1);
      check("post_rst_ar_ready", ar_ready_o, 1);

      // Same-cycle AW/W write, immediate grant, latency checks
      fork
         do_aw(16'h0040);
         do_w(32'hDEADBEEF, 4'hF);
      join
      check("wr_n_req", req_o, 0);
      check("wr_n_aw_ready", aw_ready_o, 0);
      tick(1);
      check("wr_req", req_o, 1);
      check("wr_we", we_o, 1);
      check("wr_addr", addr_o, 32'h40);
      check("wr_wdata", wdata_o, 32'hDEADBEEF);
      check("wr_be", be_o, 4'hF);
      tick(1);
      check("wr_n3_bvalid", b_valid_o, 0);
      tick(1);
      check("wr_n4_bvalid", b_valid_o, 1);
      check("wr_n4_bresp", b_resp_o, 2'b00);
      get_b(resp, 0);
      ref_write(32'h40, 32'hDEADBEEF, 4'hF);

      // Read with grant stalled three cycles and r_ready held low five cycles
      dev_mem[32'h100 >> 2] = 32'h12345678;
      ref_mem[32'h100 >> 2] = 32'h12345678;
      gnt_stall = 3;
      do_ar(16'h0100);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("rd_stall_req", req_o, 1);
         check("rd_stall_we", we_o, 0);
         check("rd_stall_be", be_o, 4'hF);
         check("rd_stall_addr", addr_o, 32'h100);
      end
      get_r(data, resp, 5);
      check("rd_data", data, ref_read(32'h100));
      check("rd_resp", resp, 2'b00);
      gnt_stall = 0;

      // W four cycles before AW, partial strobe
      do_w(32'hA5A5A5A5, 4'h3);
      for (int i = 0; i < 4; i++) begin
         check("wfirst_w_ready", w_ready_o, 0);
         check("wfirst_no_req", req_o, 0);
         tick(1);
      end
      do_aw(16'h0040);
      tick(1);
      check("wfirst_req", req_o, 1);
      check("wfirst_be", be_o, 4'h3);
      get_b(resp, 0);
      check("wfirst_bresp", resp, 2'b00);
      ref_write(32'h40, 32'hA5A5A5A5, 4'h3);

      // Error responses
      mem_err = 1'b1;
      fork
         do_aw(16'h0080);
         do_w(32'h0BAD0BAD, 4'hF);
      join
      get_b(resp, 1);
      check("err_bresp", resp, 2'b10);
      do_ar(16'h0040);
      get_r(data, resp, 0);
      check("err_rresp", resp, 2'b10);
      check("err_rdata", data, ref_read(32'h40));
      mem_err = 1'b0;

      // Write and read both eligible, twice in a row
      served_we.delete();
      d1 = $urandom; d3 = $urandom;
      fork
         do_aw(16'h0300);
         do_w(d1, 4'hF);
         do_ar(16'h0040);
      join
      fork
         do_aw(16'h0304);
         do_w(d3, 4'hF);
      join
      get_b(resp, 0);
      check("alt_b1", resp, 2'b00);
      get_r(data, resp, 0);
      check("alt_rdata", data, ref_read(32'h40));
      get_b(resp, 0);
      check("alt_b2", resp, 2'b00);
      ref_write(32'h300, d1, 4'hF);
      ref_write(32'h304, d3, 4'hF);
      check("alt_count", served_we.size(), 3);
      order = 3'b000;
      for (int i = 0; i < served_we.size() && i < 3; i++) order[2-i] = served_we[i][0];
      check("alt_order", order, 3'b101);

      // Random traffic against the reference memory
      for (int n = 0; n < 30; n++) begin
         gnt_stall = $urandom_range(0, 3);
         rv_delay  = $urandom_range(0, 2);
         e = ($urandom_range(0, 7) == 0);
         mem_err = e;
         a = 32'h200 + 4 * $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            data = $urandom;
            s = 4'($urandom_range(1, 15));
            fork
               do_aw(a[15:0]);
               do_w(data, s);
            join
            get_b(resp, $urandom_range(0, 2));
            check("rnd_bresp", resp, e ? 2'b10 : 2'b00);
            if (!e) ref_write(a, data, s);
         end else begin
            do_ar(a[15:0]);
            get_r(data, resp, $urandom_range(0, 2));
            check("rnd_rdata", data, ref_read(a));
            check("rnd_rresp", resp, e ? 2'b10 : 2'b00);
         end
      end
      mem_err = 1'b0; gnt_stall = 0;

      // Reset while waiting for the write response
      rv_delay = 6;
      fork
         do_aw(16'h0500);
         do_w(32'hCAFEF00D, 4'hF);
      join
      tick(4);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_aw_ready", aw_ready_o, 0);
      check("mid_rst_ar_ready", ar_ready_o, 0);
      check("mid_rst_req", req_o, 0);
      check("mid_rst_we", we_o, 0);
      check("mid_rst_be", be_o, 0);
      check("mid_rst_wdata", wdata_o, 0);
      check("mid_rst_b_valid", b_valid_o, 0);
      check("mid_rst_r_data", r_data_o, 0);
      check("mid_rst_r_resp", r_resp_o, 0);
      tick(2);
      rst_ni = 1'b1;
      rv_delay = 0;
      tick(1);
      check("rel_aw_ready", aw_ready_o, 1);
      check("rel_w_ready", w_ready_o, 1);
      for (int i = 0; i < 10; i++) begin
         check("rel_no_bvalid", b_valid_o, 0);
         check("rel_no_req", req_o, 0);
         tick(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
